// File: rtl/reg_bus_arbiter_pkg.sv
// reg_bus_arbiter_pkg: shared widths, FSM state and op encodings for the register-bus arbiter
package reg_bus_arbiter_pkg;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 8;
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;
  typedef enum logic {OP_READ = 1'b0, OP_WRITE = 1'b1} op_e;
endpackage

// File: rtl/reg_bus_arbiter_if.sv
// reg_bus_arbiter_if: two requester ports plus the shared register-bank bus
interface reg_bus_arbiter_if import reg_bus_arbiter_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              m0_read, m0_write, m0_ack, m0_busy;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic              m1_read, m1_write, m1_ack, m1_busy;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic              read, write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_write, data_read;
  modport slave (
    input  m0_read, m0_write, m0_addr, m0_wdata, m1_read, m1_write, m1_addr, m1_wdata, data_read,
    output m0_rdata, m0_ack, m0_busy, m1_rdata, m1_ack, m1_busy, read, write, addr, data_write
  );
  modport master (
    output m0_read, m0_write, m0_addr, m0_wdata, m1_read, m1_write, m1_addr, m1_wdata, data_read,
    input  m0_rdata, m0_ack, m0_busy, m1_rdata, m1_ack, m1_busy, read, write, addr, data_write
  );
endinterface

// File: rtl/reg_bus_arbiter_req_slot.sv
// req_slot: one-entry request buffer (pending flag, op, addr, wdata) for a single requester
module req_slot import reg_bus_arbiter_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              clr_i,
  output logic              pend_o,
  output op_e               op_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o
);
  logic              pend_q, pend_d, take;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  // a completing entry frees the slot at the same edge, so a pulse arriving then is kept
  assign take = (read_i | write_i) & (~pend_q | clr_i);
  always_comb begin
    pend_d  = take | (pend_q & ~clr_i);
    op_d    = take ? (write_i ? OP_WRITE : OP_READ) : op_q;
    addr_d  = take ? addr_i : addr_q;
    wdata_d = take ? wdata_i : wdata_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= 1'b0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      pend_q  <= pend_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  assign pend_o  = pend_q;
  assign op_o    = op_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
endmodule

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: round-robin arbiter giving two requesters single-cycle access to a register bank
module reg_bus_arbiter import reg_bus_arbiter_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic               clk,
  input logic               rst_n,
  reg_bus_arbiter_if.slave  bus
);
  state_e            state_q, state_d;
  logic              prio_q, prio_d, gnt_q, gnt_d, sel, any;
  logic              read_q, read_d, write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        ack_q, ack_d, pend, clr, cand, rd_in, wr_in;
  logic [DATA_W-1:0] rdata_q [2];
  logic [DATA_W-1:0] rdata_d [2];
  op_e               s_op [2];
  logic [ADDR_W-1:0] s_addr [2];
  logic [DATA_W-1:0] s_wdata [2];
  logic [ADDR_W-1:0] in_addr [2];
  logic [DATA_W-1:0] in_wdata [2];
  assign rd_in       = {bus.m1_read, bus.m0_read};
  assign wr_in       = {bus.m1_write, bus.m0_write};
  assign in_addr[0]  = bus.m0_addr;
  assign in_addr[1]  = bus.m1_addr;
  assign in_wdata[0] = bus.m0_wdata;
  assign in_wdata[1] = bus.m1_wdata;
  for (genvar i = 0; i < 2; i++) begin : g_slot
    req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
      .clk(clk), .rst_n(rst_n), .read_i(rd_in[i]), .write_i(wr_in[i]),
      .addr_i(in_addr[i]), .wdata_i(in_wdata[i]), .clr_i(clr[i]),
      .pend_o(pend[i]), .op_o(s_op[i]), .addr_o(s_addr[i]), .wdata_o(s_wdata[i])
    );
  end
  // the granted port's entry retires at the end of ACCESS and cannot be re-granted at that edge
  assign clr  = (state_q == ACCESS) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign cand = pend & ~clr;
  assign any  = |cand;
  assign sel  = (&cand) ? prio_q : cand[1];
  always_comb begin
    state_d = any ? ACCESS : IDLE;
    gnt_d   = any ? sel : gnt_q;
    prio_d  = any ? ~sel : prio_q;
    read_d  = any & (s_op[sel] == OP_READ);
    write_d = any & (s_op[sel] == OP_WRITE);
    addr_d  = any ? s_addr[sel] : addr_q;
    wdata_d = any ? s_wdata[sel] : wdata_q;
    ack_d   = clr;
    for (int i = 0; i < 2; i++) rdata_d[i] = (clr[i] & read_q) ? bus.data_read : rdata_q[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      gnt_q      <= 1'b0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ack_q      <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      gnt_q      <= gnt_d;
      read_q     <= read_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ack_q      <= ack_d;
      rdata_q[0] <= rdata_d[0];
      rdata_q[1] <= rdata_d[1];
    end
  end
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.addr       = addr_q;
  assign bus.data_write = wdata_q;
  assign bus.m0_ack     = ack_q[0];
  assign bus.m1_ack     = ack_q[1];
  assign bus.m0_busy    = pend[0];
  assign bus.m1_busy    = pend[1];
  assign bus.m0_rdata   = rdata_q[0];
  assign bus.m1_rdata   = rdata_q[1];
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: randomized scoreboard bench against a transaction-level arbitration model
module tb_reg_bus_arbiter;
  import reg_bus_arbiter_pkg::*;
  localparam int AW = DEF_ADDR_W;
  localparam int DW = DEF_DATA_W;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  reg_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  reg_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [DW-1:0] bank [1<<AW];
  assign bus.data_read = bank[bus.addr];
  typedef struct { int cyc; int port; bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; } bus_t;
  typedef struct { int cyc; logic [DW-1:0] rdata; } ack_t;
  bus_t bus_q[$];
  ack_t ack0_q[$];
  ack_t ack1_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  // model: per-port request, the access on the bus, and which port wins the next tie
  bit            pend [2];
  bit            op_m [2];
  logic [AW-1:0] a_m [2];
  logic [DW-1:0] d_m [2];
  logic [DW-1:0] rd_m [2];
  int            cur, prio;
  bit            cur_wr;
  logic [AW-1:0] cur_a, last_a;
  logic [DW-1:0] last_d;
  bit            in_rd [2];
  bit            in_wr [2];
  logic [AW-1:0] in_a [2];
  logic [DW-1:0] in_d [2];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic model_reset();
    pend = '{0, 0};
    rd_m = '{0, 0};
    cur = -1;
    prio = 0;
    last_a = '0;
    last_d = '0;
    bus_q.delete();
    ack0_q.delete();
    ack1_q.delete();
  endtask
  task automatic model_step();
    cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (cur >= 0) begin
      pend[cur] = 0;
      if (!cur_wr) rd_m[cur] = bank[cur_a];
    end
    cur = -1;
    if (pend[0] || pend[1]) begin
      int g;
      ack_t k;
      g = (pend[0] && pend[1]) ? prio : (pend[1] ? 1 : 0);
      cur = g;
      prio = 1 - g;
      cur_wr = op_m[g];
      cur_a = a_m[g];
      last_a = a_m[g];
      last_d = d_m[g];
      bus_q.push_back('{cyc, g, op_m[g], a_m[g], d_m[g]});
      k = '{cyc + 1, op_m[g] ? rd_m[g] : bank[a_m[g]]};
      if (g == 0) ack0_q.push_back(k); else ack1_q.push_back(k);
    end
    for (int p = 0; p < 2; p++)
      if ((in_rd[p] || in_wr[p]) && !pend[p]) begin
        pend[p] = 1;
        op_m[p] = in_wr[p];
        a_m[p] = in_a[p];
        d_m[p] = in_d[p];
      end
  endtask
  task automatic set_in(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    in_rd = '{r0, r1};
    in_wr = '{w0, w1};
    in_a = '{a0, a1};
    in_d = '{d0, d1};
    bus.m0_read = r0; bus.m0_write = w0; bus.m0_addr = a0; bus.m0_wdata = d0;
    bus.m1_read = r1; bus.m1_write = w1; bus.m1_addr = a1; bus.m1_wdata = d1;
  endtask
  task automatic drive(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    @(posedge clk);
    model_step();
    #1;
    set_in(r0, w0, a0, d0, r1, w1, a1, d1);
  endtask
  task automatic idle(input int n);
    repeat (n) drive(0, 0, '0, '0, 0, 0, '0, '0);
  endtask
  task automatic do_reset(input int n);
    @(posedge clk);
    model_step();
    #1;
    rst_n = 1'b0;
    model_reset();
    set_in(0, 0, '0, '0, 0, 0, '0, '0);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
    end
    rst_n = 1'b1;
  endtask
  always @(negedge clk) begin
    if (bus_q.size() > 0 && bus_q[0].cyc == cyc) begin
      bus_t e;
      e = bus_q.pop_front();
      chk("bus_write", bus.write, e.wr);
      chk("bus_read", bus.read, !e.wr);
      chk("bus_addr", bus.addr, e.addr);
      chk("bus_data_write", bus.data_write, e.wdata);
    end else begin
      chk("idle_read", bus.read, 0);
      chk("idle_write", bus.write, 0);
      chk("hold_addr", bus.addr, last_a);
      chk("hold_data_write", bus.data_write, last_d);
    end
    if (ack0_q.size() > 0 && ack0_q[0].cyc == cyc) begin
      ack_t e;
      e = ack0_q.pop_front();
      chk("m0_ack", bus.m0_ack, 1);
      chk("m0_rdata_ack", bus.m0_rdata, e.rdata);
    end else begin
      chk("m0_ack_idle", bus.m0_ack, 0);
      chk("m0_rdata_hold", bus.m0_rdata, rd_m[0]);
    end
    if (ack1_q.size() > 0 && ack1_q[0].cyc == cyc) begin
      ack_t e;
      e = ack1_q.pop_front();
      chk("m1_ack", bus.m1_ack, 1);
      chk("m1_rdata_ack", bus.m1_rdata, e.rdata);
    end else begin
      chk("m1_ack_idle", bus.m1_ack, 0);
      chk("m1_rdata_hold", bus.m1_rdata, rd_m[1]);
    end
    chk("m0_busy", bus.m0_busy, pend[0]);
    chk("m1_busy", bus.m1_busy, pend[1]);
  end
  initial begin
    for (int i = 0; i < (1 << AW); i++) bank[i] = DW'($urandom);
    bank[2] = 8'h3C;
    model_reset();
    set_in(0, 0, '0, '0, 0, 0, '0, '0);
    idle(3);
    rst_n = 1'b1;
    idle(2);
    drive(0, 1, 6'h05, 8'hA5, 0, 0, '0, '0);
    idle(4);
    drive(0, 0, '0, '0, 1, 0, 6'h02, 8'h00);
    idle(4);
    repeat (10) drive(1, 0, AW'($urandom), DW'($urandom), 0, 1, AW'($urandom), DW'($urandom));
    idle(4);
    drive(1, 0, 6'h03, 8'h11, 0, 0, '0, '0);
    drive(1, 0, 6'h07, 8'h22, 0, 0, '0, '0);
    idle(4);
    drive(1, 1, 6'h01, 8'h5A, 0, 0, '0, '0);
    idle(4);
    drive(0, 1, 6'h09, 8'h77, 0, 0, '0, '0);
    idle(1);
    do_reset(2);
    idle(3);
    drive(1, 0, 6'h02, 8'h00, 0, 0, '0, '0);
    idle(4);
    repeat (600) begin
      if ($urandom_range(0, 99) == 0) do_reset(1);
      else drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, AW'($urandom), DW'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, AW'($urandom), DW'($urandom));
    end
    idle(6);
    chk("bus_queue_drained", bus_q.size(), 0);
    chk("m0_ack_queue_drained", ack0_q.size(), 0);
    chk("m1_ack_queue_drained", ack1_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
